// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, bubble
// instruction, ALU operation encodings and immediate formats.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Immediate format implied by the opcode; R-type and unknown opcodes carry none.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: return IMM_I;
      OPC_STORE:                     return IMM_S;
      OPC_BRANCH:                    return IMM_B;
      OPC_LUI, OPC_AUIPC:            return IMM_U;
      OPC_JAL:                       return IMM_J;
      default:                       return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: rebuilds the sign-extended 32-bit
// immediate from the instruction word according to its opcode's format.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0]        i_instr,
  output logic signed [31:0] o_imm
);

  // Scatter/gather of the immediate bits per format, sign bit is always instr[31].
  always_comb begin
    o_imm = '0;
    case (imm_fmt(i_instr[6:0]))
      IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   o_imm = {i_instr[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, register-file read, load-use hazard
// detection and the ID/EX pipeline register.
// Optional build macro DECODE_WB_BYPASS_EN forwards the writeback port onto
// the source operands for register files without write-before-read.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_C,
  parameter logic [31:0] INITIAL_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dst_in_instr,
  input  logic [31:0] dst_in_pc,
  input  logic [31:0] dst_in_pc_next,
  input  logic        dst_in_flush,
  input  logic [4:0]  dst_in_ex_rd,
  input  logic        dst_in_ex_mem_read,
  output logic [4:0]  dst_out_rs1_addr,
  output logic [4:0]  dst_out_rs2_addr,
  input  logic [31:0] dst_in_rs1_data,
  input  logic [31:0] dst_in_rs2_data,
  input  logic        dst_in_wb_we,
  input  logic [4:0]  dst_in_wb_rd,
  input  logic [31:0] dst_in_wb_data,
  output logic        dst_out_stall,
  output logic [31:0] dst_out_instr,
  output logic [31:0] dst_out_pc,
  output logic [31:0] dst_out_pc_next,
  output logic [31:0] dst_out_rs1_data,
  output logic [31:0] dst_out_rs2_data,
  output logic [31:0] dst_out_imm,
  output logic [4:0]  dst_out_rd,
  output logic [2:0]  dst_out_funct3,
  output logic [3:0]  dst_out_alu_op,
  output logic        dst_out_reg_write,
  output logic        dst_out_mem_read,
  output logic        dst_out_mem_write,
  output logic        dst_out_branch,
  output logic        dst_out_jump,
  output logic        dst_out_alu_src_imm,
  output logic        dst_out_illegal
);

  // ALU operation for OP / OP-IMM; only OP has SUB, both have SRA via instr[30].
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b30,
                                         input logic is_op);
    case (f3)
      3'd0:    return (is_op && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return b30 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]         w_opc;
  logic [4:0]         w_rs1, w_rs2, w_rd;
  logic [2:0]         w_funct3;
  logic signed [31:0] w_imm;
  logic [31:0]        w_rs1_data, w_rs2_data;
  logic               w_legal, w_use_rs1, w_use_rs2, w_rw, w_mr, w_mw;
  logic               w_br, w_jp, w_ai;
  logic [3:0]         w_alu;
  logic               w_stall, w_bubble;

  assign w_opc    = dst_in_instr[6:0];
  assign w_rd     = dst_in_instr[11:7];
  assign w_funct3 = dst_in_instr[14:12];
  assign w_rs1    = dst_in_instr[19:15];
  assign w_rs2    = dst_in_instr[24:20];

  assign dst_out_rs1_addr = w_rs1;
  assign dst_out_rs2_addr = w_rs2;

  decode_stage_imm_gen u_imm_gen (
    .i_instr (dst_in_instr),
    .o_imm   (w_imm)
  );

  // Control decode and source-register usage per opcode.
  always_comb begin
    w_legal = 1'b0; w_use_rs1 = 1'b0; w_use_rs2 = 1'b0;
    w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_br = 1'b0; w_jp = 1'b0;
    w_ai = 1'b0; w_alu = ALU_ADD;
    case (w_opc)
      OPC_LUI:    begin w_legal = 1'b1; w_rw = 1'b1; w_ai = 1'b1; w_alu = ALU_PASS_B; end
      OPC_AUIPC:  begin w_legal = 1'b1; w_rw = 1'b1; w_ai = 1'b1; end
      OPC_JAL:    begin w_legal = 1'b1; w_rw = 1'b1; w_jp = 1'b1; w_ai = 1'b1; end
      OPC_JALR:   begin w_legal = 1'b1; w_rw = 1'b1; w_jp = 1'b1; w_ai = 1'b1;
                        w_use_rs1 = 1'b1; end
      OPC_BRANCH: begin w_legal = 1'b1; w_br = 1'b1; w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1; w_alu = ALU_SUB; end
      OPC_LOAD:   begin w_legal = 1'b1; w_rw = 1'b1; w_mr = 1'b1; w_ai = 1'b1;
                        w_use_rs1 = 1'b1; end
      OPC_STORE:  begin w_legal = 1'b1; w_mw = 1'b1; w_ai = 1'b1;
                        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_OPIMM:  begin w_legal = 1'b1; w_rw = 1'b1; w_ai = 1'b1; w_use_rs1 = 1'b1;
                        w_alu = alu_dec(w_funct3, dst_in_instr[30], 1'b0); end
      OPC_OP:     begin w_legal = 1'b1; w_rw = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                        w_alu = alu_dec(w_funct3, dst_in_instr[30], 1'b1); end
      default:    ;
    endcase
  end

  // A flush squashes the instruction anyway, so it masks the stall request.
  assign w_stall = dst_in_ex_mem_read && (dst_in_ex_rd != 5'd0) && !dst_in_flush &&
                   ((w_use_rs1 && dst_in_ex_rd == w_rs1) ||
                    (w_use_rs2 && dst_in_ex_rd == w_rs2));
  assign dst_out_stall = w_stall;
  assign w_bubble      = dst_in_flush || w_stall;

`ifdef DECODE_WB_BYPASS_EN
  // Source operands: x0 reads zero, a same-cycle writeback overrides the file.
  always_comb begin
    w_rs1_data = dst_in_rs1_data;
    w_rs2_data = dst_in_rs2_data;
    if (dst_in_wb_we && dst_in_wb_rd != 5'd0 && dst_in_wb_rd == w_rs1)
      w_rs1_data = dst_in_wb_data;
    if (dst_in_wb_we && dst_in_wb_rd != 5'd0 && dst_in_wb_rd == w_rs2)
      w_rs2_data = dst_in_wb_data;
    if (w_rs1 == 5'd0) w_rs1_data = '0;
    if (w_rs2 == 5'd0) w_rs2_data = '0;
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{dst_in_wb_we, dst_in_wb_rd, dst_in_wb_data};

  // Source operands: x0 reads zero, otherwise register-file data as-is.
  always_comb begin
    w_rs1_data = (w_rs1 == 5'd0) ? '0 : dst_in_rs1_data;
    w_rs2_data = (w_rs2 == 5'd0) ? '0 : dst_in_rs2_data;
  end
`endif

  // ---- ID/EX register boundary: reset > bubble (flush/stall) > decoded ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_out_instr <= NOP_INSTR;          dst_out_pc <= INITIAL_PC;
      dst_out_pc_next <= INITIAL_PC + 32'd4;
      dst_out_rs1_data <= '0; dst_out_rs2_data <= '0; dst_out_imm <= '0;
      dst_out_rd <= '0; dst_out_funct3 <= '0; dst_out_alu_op <= ALU_ADD;
      dst_out_reg_write <= 1'b0; dst_out_mem_read <= 1'b0; dst_out_mem_write <= 1'b0;
      dst_out_branch <= 1'b0; dst_out_jump <= 1'b0; dst_out_alu_src_imm <= 1'b0;
      dst_out_illegal <= 1'b0;
    end else if (w_bubble) begin
      dst_out_instr <= NOP_INSTR;          dst_out_pc <= dst_in_pc;
      dst_out_pc_next <= dst_in_pc_next;
      dst_out_rs1_data <= '0; dst_out_rs2_data <= '0; dst_out_imm <= '0;
      dst_out_rd <= '0; dst_out_funct3 <= '0; dst_out_alu_op <= ALU_ADD;
      dst_out_reg_write <= 1'b0; dst_out_mem_read <= 1'b0; dst_out_mem_write <= 1'b0;
      dst_out_branch <= 1'b0; dst_out_jump <= 1'b0; dst_out_alu_src_imm <= 1'b0;
      dst_out_illegal <= 1'b0;
    end else begin
      dst_out_instr <= dst_in_instr;       dst_out_pc <= dst_in_pc;
      dst_out_pc_next <= dst_in_pc_next;
      dst_out_rs1_data <= w_rs1_data; dst_out_rs2_data <= w_rs2_data;
      dst_out_imm <= w_imm; dst_out_rd <= w_rd; dst_out_funct3 <= w_funct3;
      dst_out_alu_op <= w_alu;
      dst_out_reg_write <= w_rw && (w_rd != 5'd0);
      dst_out_mem_read <= w_mr; dst_out_mem_write <= w_mw;
      dst_out_branch <= w_br; dst_out_jump <= w_jp; dst_out_alu_src_imm <= w_ai;
      dst_out_illegal <= !w_legal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases followed by randomized instructions,
// each checked against a behavioural model of the decode rules.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk, reset;
  logic [31:0] dst_in_instr, dst_in_pc, dst_in_pc_next;
  logic        dst_in_flush, dst_in_ex_mem_read;
  logic [4:0]  dst_in_ex_rd;
  logic [4:0]  dst_out_rs1_addr, dst_out_rs2_addr;
  logic [31:0] dst_in_rs1_data, dst_in_rs2_data;
  logic        dst_in_wb_we;
  logic [4:0]  dst_in_wb_rd;
  logic [31:0] dst_in_wb_data;
  logic        dst_out_stall;
  logic [31:0] dst_out_instr, dst_out_pc, dst_out_pc_next;
  logic [31:0] dst_out_rs1_data, dst_out_rs2_data, dst_out_imm;
  logic [4:0]  dst_out_rd;
  logic [2:0]  dst_out_funct3;
  logic [3:0]  dst_out_alu_op;
  logic        dst_out_reg_write, dst_out_mem_read, dst_out_mem_write;
  logic        dst_out_branch, dst_out_jump, dst_out_alu_src_imm, dst_out_illegal;

  int n_chk = 0;
  int n_err = 0;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .dst_in_instr(dst_in_instr), .dst_in_pc(dst_in_pc), .dst_in_pc_next(dst_in_pc_next),
    .dst_in_flush(dst_in_flush), .dst_in_ex_rd(dst_in_ex_rd),
    .dst_in_ex_mem_read(dst_in_ex_mem_read),
    .dst_out_rs1_addr(dst_out_rs1_addr), .dst_out_rs2_addr(dst_out_rs2_addr),
    .dst_in_rs1_data(dst_in_rs1_data), .dst_in_rs2_data(dst_in_rs2_data),
    .dst_in_wb_we(dst_in_wb_we), .dst_in_wb_rd(dst_in_wb_rd), .dst_in_wb_data(dst_in_wb_data),
    .dst_out_stall(dst_out_stall),
    .dst_out_instr(dst_out_instr), .dst_out_pc(dst_out_pc), .dst_out_pc_next(dst_out_pc_next),
    .dst_out_rs1_data(dst_out_rs1_data), .dst_out_rs2_data(dst_out_rs2_data),
    .dst_out_imm(dst_out_imm), .dst_out_rd(dst_out_rd), .dst_out_funct3(dst_out_funct3),
    .dst_out_alu_op(dst_out_alu_op),
    .dst_out_reg_write(dst_out_reg_write), .dst_out_mem_read(dst_out_mem_read),
    .dst_out_mem_write(dst_out_mem_write), .dst_out_branch(dst_out_branch),
    .dst_out_jump(dst_out_jump), .dst_out_alu_src_imm(dst_out_alu_src_imm),
    .dst_out_illegal(dst_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, pc_next, rs1d, rs2d, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [6:0]  ctrl;   // {reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal}
    logic        stall;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {dst_out_reg_write, dst_out_mem_read, dst_out_mem_write, dst_out_branch,
            dst_out_jump, dst_out_alu_src_imm, dst_out_illegal};
  endfunction

  // Operand value as the decode stage should present it.
  function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (dst_in_wb_we && dst_in_wb_rd == a) return dst_in_wb_data;
`endif
    return rf;
  endfunction

  // Reference model of one decode cycle, from the current inputs.
  function automatic exp_t model();
    exp_t e;
    logic [31:0] in;
    int imm;
    bit legal, u1, u2, rw, mr, mw, br, jp, ai;
    logic [3:0] alu;
    logic [3:0] alu_tab [8];
    alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    in = dst_in_instr;
    {legal, u1, u2, rw, mr, mw, br, jp, ai} = '0;
    alu = ALU_ADD;
    imm = 0;
    case (in[6:0])
      7'h37: begin legal = 1; rw = 1; ai = 1; alu = ALU_PASS_B; imm = int'(in & 32'hFFFFF000); end
      7'h17: begin legal = 1; rw = 1; ai = 1; imm = int'(in & 32'hFFFFF000); end
      7'h6F: begin legal = 1; rw = 1; jp = 1; ai = 1;
        imm = int'(in[31]) * (1 << 20) + int'(in[19:12]) * (1 << 12) +
              int'(in[20]) * (1 << 11) + int'(in[30:21]) * 2;
        if (imm >= (1 << 20)) imm -= (1 << 21);
      end
      7'h63: begin legal = 1; br = 1; u1 = 1; u2 = 1; alu = ALU_SUB;
        imm = int'(in[31]) * 4096 + int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2;
        if (imm >= 4096) imm -= 8192;
      end
      7'h23: begin legal = 1; mw = 1; ai = 1; u1 = 1; u2 = 1;
        imm = int'(in[31:25]) * 32 + int'(in[11:7]);
        if (imm >= 2048) imm -= 4096;
      end
      7'h67, 7'h03, 7'h13: begin
        legal = 1; rw = 1; ai = 1; u1 = 1;
        jp = (in[6:0] == 7'h67);
        mr = (in[6:0] == 7'h03);
        if (in[6:0] == 7'h13) alu = (in[14:12] == 5 && in[30]) ? ALU_SRA : alu_tab[in[14:12]];
        imm = int'(in[31:20]);
        if (imm >= 2048) imm -= 4096;
      end
      7'h33: begin legal = 1; rw = 1; u1 = 1; u2 = 1;
        alu = alu_tab[in[14:12]];
        if (in[30] && in[14:12] == 5) alu = ALU_SRA;
        if (in[30] && in[14:12] == 0) alu = ALU_SUB;
      end
      default: ;
    endcase
    e.stall = dst_in_ex_mem_read && dst_in_ex_rd != 0 && !dst_in_flush &&
              ((u1 && dst_in_ex_rd == in[19:15]) || (u2 && dst_in_ex_rd == in[24:20]));
    e.pc = dst_in_pc;
    e.pc_next = dst_in_pc_next;
    if (dst_in_flush || e.stall) begin
      e.instr = NOP_INSTR_C; e.rs1d = 0; e.rs2d = 0; e.imm = 0;
      e.rd = 0; e.f3 = 0; e.alu = ALU_ADD; e.ctrl = 0;
    end else begin
      e.instr = in;
      e.rs1d = src_val(in[19:15], dst_in_rs1_data);
      e.rs2d = src_val(in[24:20], dst_in_rs2_data);
      e.imm = imm;
      e.rd = in[11:7];
      e.f3 = in[14:12];
      e.alu = alu;
      e.ctrl = {rw && in[11:7] != 0, mr, mw, br, jp, ai, !legal};
    end
    return e;
  endfunction

  // Check combinational outputs, clock once, check the registered result.
  task automatic step(input string nm);
    exp_t e;
    #1;
    e = model();
    chk({nm, ":stall"}, 32'(dst_out_stall), 32'(e.stall));
    chk({nm, ":rs1a"}, 32'(dst_out_rs1_addr), 32'(dst_in_instr[19:15]));
    chk({nm, ":rs2a"}, 32'(dst_out_rs2_addr), 32'(dst_in_instr[24:20]));
    @(posedge clk);
    #1;
    chk({nm, ":instr"}, dst_out_instr, e.instr);
    chk({nm, ":pc"}, dst_out_pc, e.pc);
    chk({nm, ":pcn"}, dst_out_pc_next, e.pc_next);
    chk({nm, ":rs1d"}, dst_out_rs1_data, e.rs1d);
    chk({nm, ":rs2d"}, dst_out_rs2_data, e.rs2d);
    chk({nm, ":imm"}, dst_out_imm, e.imm);
    chk({nm, ":rd"}, 32'(dst_out_rd), 32'(e.rd));
    chk({nm, ":f3"}, 32'(dst_out_funct3), 32'(e.f3));
    chk({nm, ":alu"}, 32'(dst_out_alu_op), 32'(e.alu));
    chk({nm, ":ctrl"}, 32'(ctrl_now()), 32'(e.ctrl));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ":instr"}, dst_out_instr, 32'h00000013);
    chk({nm, ":pc"}, dst_out_pc, 32'h00001000);
    chk({nm, ":pcn"}, dst_out_pc_next, 32'h00001004);
    chk({nm, ":imm"}, dst_out_imm, 32'd0);
    chk({nm, ":rs1d"}, dst_out_rs1_data, 32'd0);
    chk({nm, ":rd"}, 32'(dst_out_rd), 32'd0);
    chk({nm, ":ctrl"}, 32'(ctrl_now()), 32'd0);
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [31:0] pc);
    dst_in_instr = ins; dst_in_pc = pc; dst_in_pc_next = pc + 32'd4;
  endtask

  logic [6:0] legal_opc [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    reset = 1'b1;
    set_in(32'h00000013, 32'h0);
    dst_in_flush = 0; dst_in_ex_rd = 0; dst_in_ex_mem_read = 0;
    dst_in_rs1_data = 0; dst_in_rs2_data = 0;
    dst_in_wb_we = 0; dst_in_wb_rd = 0; dst_in_wb_data = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) reset = 1'b0;

    // addi x5,x1,-1 with x1 = 7
    set_in(32'hFFF08293, 32'h2000); dst_in_rs1_data = 32'd7;
    step("addi");
    chk("addi:imm_k", dst_out_imm, 32'hFFFFFFFF);
    chk("addi:rd_k", 32'(dst_out_rd), 32'd5);
    chk("addi:rw_ai_k", 32'({dst_out_reg_write, dst_out_alu_src_imm}), 32'd3);
    chk("addi:rs1d_k", dst_out_rs1_data, 32'd7);

    // load-use on add x4,x3,x2 then release
    @(negedge clk);
    set_in(32'h00218233, 32'h2004); dst_in_ex_mem_read = 1; dst_in_ex_rd = 5'd3;
    dst_in_rs1_data = 32'h33; dst_in_rs2_data = 32'h22;
    #1 chk("lu:stall_k", 32'(dst_out_stall), 32'd1);
    step("lu_bubble");
    chk("lu:nop_k", dst_out_instr, 32'h00000013);
    @(negedge clk); dst_in_ex_mem_read = 0;
    step("lu_release");
    chk("lu:instr_k", dst_out_instr, 32'h00218233);

    // flush and stall together, then branch target
    @(negedge clk);
    dst_in_ex_mem_read = 1; dst_in_ex_rd = 5'd3; dst_in_flush = 1;
    #1 chk("fs:stall_k", 32'(dst_out_stall), 32'd0);
    step("fs_bubble");
    chk("fs:nop_k", dst_out_instr, 32'h00000013);
    @(negedge clk);
    dst_in_flush = 0; dst_in_ex_mem_read = 0; set_in(32'h00500093, 32'h3000);
    step("fs_target");
    chk("fs:pc_k", dst_out_pc, 32'h3000);

    // beq x0,x0,-8
    @(negedge clk); set_in(32'hFE000CE3, 32'h3004);
    step("beq");
    chk("beq:imm_k", dst_out_imm, 32'hFFFFFFF8);
    chk("beq:br_rw_k", 32'({dst_out_branch, dst_out_reg_write}), 32'd2);

    // unknown opcode
    @(negedge clk); set_in(32'h0000007F, 32'h3008);
    step("illegal");
    chk("ill:ctrl_k", 32'(ctrl_now()), 32'd1);

`ifdef DECODE_WB_BYPASS_EN
    @(negedge clk);
    set_in(32'h00008113, 32'h300C); dst_in_rs1_data = 32'h55;
    dst_in_wb_we = 1; dst_in_wb_rd = 5'd1; dst_in_wb_data = 32'hAB;
    step("bypass");
    chk("byp:rs1d_k", dst_out_rs1_data, 32'hAB);
    dst_in_wb_we = 0;
`endif

    // randomized instructions and hazard/flush/writeback conditions
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      @(negedge clk);
      r = $urandom;
      if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
      else r[6:0] = legal_opc[$urandom_range(0, 8)];
      set_in(r, $urandom & 32'hFFFFFFFC);
      dst_in_rs1_data = $urandom; dst_in_rs2_data = $urandom;
      dst_in_flush = ($urandom_range(0, 7) == 0);
      dst_in_ex_mem_read = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: dst_in_ex_rd = r[19:15];
        1: dst_in_ex_rd = r[24:20];
        default: dst_in_ex_rd = 5'($urandom);
      endcase
      dst_in_wb_we = 1'($urandom);
      dst_in_wb_rd = ($urandom_range(0, 1) == 1) ? r[19:15] : 5'($urandom);
      dst_in_wb_data = $urandom;
      step("rand");
      if (i == 150) begin
        // asynchronous reset between edges
        @(negedge clk); #2 reset = 1'b1;
        #1 chk_reset("rst_mid");
        @(negedge clk) reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage; sits directly downstream of the fetch stage and consumes its registered instr/pc/pc_next.
- Decodes opcode, reads the external register file, builds the sign-extended immediate and drives the ID/EX pipeline register toward execute.
- Detects load-use hazards (stalls fetch, inserts a bubble) and squashes the wrong-path instruction on a taken branch.

Parameters:
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) reported on dst_out_instr when squashed.
- INITIAL_PC, 32'h1000, reset value of dst_out_pc; dst_out_pc_next resets to INITIAL_PC+4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- dst_in_instr  in  32  instruction from fetch.
- dst_in_pc  in  32  pc of dst_in_instr.
- dst_in_pc_next  in  32  pc+4 from fetch.
- dst_in_flush  in  1  taken branch/jump from execute (same signal fetch receives).
- dst_in_ex_rd  in  5  rd of the instruction now in execute.
- dst_in_ex_mem_read  in  1  execute instruction is a load.
- dst_out_rs1_addr, dst_out_rs2_addr  out  5  combinational register-file read addresses.
- dst_in_rs1_data, dst_in_rs2_data  in  32  register-file read data (same cycle).
- dst_in_wb_we  in  1  writeback write enable.
- dst_in_wb_rd  in  5  writeback destination.
- dst_in_wb_data  in  32  writeback data.
- dst_out_stall  out  1  combinational; freezes fetch this cycle.
- dst_out_instr, dst_out_pc, dst_out_pc_next  out  32  registered pass-through.
- dst_out_rs1_data, dst_out_rs2_data, dst_out_imm  out  32  registered.
- dst_out_rd  out  5  registered.
- dst_out_funct3  out  3  registered.
- dst_out_alu_op  out  4  registered encoded ALU operation.
- dst_out_reg_write, dst_out_mem_read, dst_out_mem_write, dst_out_branch, dst_out_jump, dst_out_alu_src_imm, dst_out_illegal  out  1  registered control.

Behaviour:
- Reset (async): instr=NOP_INSTR, pc=INITIAL_PC, pc_next=INITIAL_PC+4, all data fields 0, all control bits 0.
- Latency: one cycle; every output except rs*_addr and stall is updated on the rising clk edge.
- rs1_addr=instr[19:15], rs2_addr=instr[24:20], driven combinationally.
- Hazard: stall = dst_in_ex_mem_read & (ex_rd!=0) & (ex_rd==rs1 used | ex_rd==rs2 used) & !dst_in_flush. Use of each source is decided per opcode: U and J types use neither; I-type and loads use rs1 only.
- Priority at each edge: reset > flush > stall > normal.
  - flush: load a bubble (NOP_INSTR, all control 0, illegal 0).
  - stall: load a bubble; fetch holds, so the same instruction is re-presented next cycle.
  - normal: load the decoded instruction.
- Flush and stall on the same cycle: flush wins; stall output is 0.
- Immediate by format:
  - I: instr[31:20] sign-extended.
  - S: {31:25, 11:7}.
  - B: {31, 7, 30:25, 11:8, 0}.
  - U: {31:12, 12'b0}.
  - J: {31, 19:12, 20, 30:21, 0}.
  - All sign-extended to 32 bits; R-type imm=0.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode: illegal=1, all other control 0, instr/pc still passed through.
  - Execute raises the exception.
- rd=0: reg_write forced to 0.
- x0 reads: rs*_data is forced to 0 regardless of dst_in_rs*_data.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: if dst_in_wb_we & wb_rd!=0 & wb_rd==rsN, then rsN_data takes dst_in_wb_data instead of the register-file data. This handles a register file without write-before-read.
- Undefined: register-file data is used as-is; the register file must write in the first half-cycle.

Decomposition:
- Shared package/include: opcode localparams, NOP, ALU op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), immediate-format enum.
- One natural sub-module: imm_gen (combinational instr -> imm by opcode).
- Hazard logic and control decode stay in decode_stage.

Test Plan:
- Reset mid-run: outputs return to NOP/0x1000/0x1004 immediately, before the next clk edge.
- Decode addi x5,x1,-1 (0xFFF08293), rs1_data=7 -> next edge: rd=5, imm=0xFFFFFFFF, alu_src_imm=1, reg_write=1, rs1_data=7.
- Load-use: ex_mem_read=1, ex_rd=3, instr add x4,x3,x2 -> stall=1 and a bubble is emitted. Next cycle with ex_mem_read=0 -> add is decoded.
- Flush and stall on the same cycle -> stall=0, bubble emitted; next decoded instruction is the branch target.
- B-type beq offset -8 (0xFE000CE3) -> imm=0xFFFFFFF8, branch=1, reg_write=0.
- Opcode 0x7F -> illegal=1, control 0. With DECODE_WB_BYPASS_EN: wb_we=1, wb_rd=1, wb_data=0xAB, rs1=1 -> rs1_data=0xAB.
